// File: rtl/sample_ram_arbiter_if.sv
// Purpose : bundles the two requester ports (bridge B, FFT core C) and the sample RAM port.
// Latency : n/a, wiring only.
// Backpressure: none here; the arbiter's grants are the only flow control.
// Modports: slave  - the arbiter (drives grants, read returns, RAM strobes, busy)
//           master - the environment (drives requests, write data, RAM read data)
interface sample_ram_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    // bridge requester
    logic                  i_B_REQ;
    logic                  i_B_WE;
    logic [ADDR_WIDTH-1:0] i_B_ADR;
    logic [DATA_WIDTH-1:0] i_B_WDATA;
    logic                  o_B_GNT;
    logic                  o_B_RVALID;
    logic [DATA_WIDTH-1:0] o_B_RDATA;
    // FFT-core requester
    logic                  i_C_REQ;
    logic                  i_C_WE;
    logic [ADDR_WIDTH-1:0] i_C_ADR;
    logic [DATA_WIDTH-1:0] i_C_WDATA;
    logic                  o_C_GNT;
    logic                  o_C_RVALID;
    logic [DATA_WIDTH-1:0] o_C_RDATA;
    // sample RAM
    logic                  o_WRITE_ram;
    logic                  o_READ_ram;
    logic [ADDR_WIDTH-1:0] o_SAMPLE_INDEX_ram;
    logic [DATA_WIDTH-1:0] o_SAMPLE_ram;
    logic [DATA_WIDTH-1:0] i_DATA_FROM_RAM;
    // status
    logic                  o_BUSY;

    modport slave (
        input  i_B_REQ, i_B_WE, i_B_ADR, i_B_WDATA,
        output o_B_GNT, o_B_RVALID, o_B_RDATA,
        input  i_C_REQ, i_C_WE, i_C_ADR, i_C_WDATA,
        output o_C_GNT, o_C_RVALID, o_C_RDATA,
        output o_WRITE_ram, o_READ_ram, o_SAMPLE_INDEX_ram, o_SAMPLE_ram,
        input  i_DATA_FROM_RAM,
        output o_BUSY
    );

    modport master (
        output i_B_REQ, i_B_WE, i_B_ADR, i_B_WDATA,
        input  o_B_GNT, o_B_RVALID, o_B_RDATA,
        output i_C_REQ, i_C_WE, i_C_ADR, i_C_WDATA,
        input  o_C_GNT, o_C_RVALID, o_C_RDATA,
        input  o_WRITE_ram, o_READ_ram, o_SAMPLE_INDEX_ram, o_SAMPLE_ram,
        output i_DATA_FROM_RAM,
        input  o_BUSY
    );
endinterface

// File: rtl/sample_ram_arbiter.sv
// Purpose : two-requester (bridge B, FFT core C) arbiter in front of a single-port sample RAM.
// Latency : request sampled in cycle N, grant in N+1; read data/rvalid return one cycle after the read beat.
// Backpressure: a requester only moves when its grant is high; a beat is any granted cycle with REQ=1.
// Ports   : i_clk, i_rst (synchronous, active high), bus (sample_ram_arbiter_if.slave):
//           B/C request, write-enable, address, write data in; grant, rvalid, rdata out;
//           RAM write/read strobes, index, write data out; RAM read data in; busy out.
// Option  : define ARB_BURST_LIMIT_EN to force a yield after MAX_BURST beats when the other side waits.
module sample_ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_BURST  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sample_ram_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_B = 2'd1,
        GNT_C = 2'd2
    } state_t;

    // one requester's access, as seen at the RAM side
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] wdata;
    } acc_t;

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    state_t                state;
    logic                  last_c;      // 1: C was served last, so B wins the next tie
    logic [CNT_W-1:0]      beat_cnt;
    logic                  rvalid_b;
    logic                  rvalid_c;
    logic [DATA_WIDTH-1:0] rdata_b_q;
    logic [DATA_WIDTH-1:0] rdata_c_q;

    acc_t acc_b;
    acc_t acc_c;
    acc_t acc_sel;
    logic beat_b;
    logic beat_c;
    logic beat_any;

    assign acc_b = {bus.i_B_WE, bus.i_B_ADR, bus.i_B_WDATA};
    assign acc_c = {bus.i_C_WE, bus.i_C_ADR, bus.i_C_WDATA};

    assign beat_b   = (state == GNT_B) && bus.i_B_REQ;
    assign beat_c   = (state == GNT_C) && bus.i_C_REQ;
    assign beat_any = beat_b | beat_c;
    assign acc_sel  = beat_c ? acc_c : acc_b;

    // RAM port is driven straight from the granted requester and forced to zero otherwise
    assign bus.o_WRITE_ram        = beat_any &  acc_sel.we;
    assign bus.o_READ_ram         = beat_any & ~acc_sel.we;
    assign bus.o_SAMPLE_INDEX_ram = beat_any ? acc_sel.adr   : '0;
    assign bus.o_SAMPLE_ram       = beat_any ? acc_sel.wdata : '0;

    assign bus.o_B_GNT = (state == GNT_B);
    assign bus.o_C_GNT = (state == GNT_C);
    assign bus.o_BUSY  = (state != IDLE);

    // Read data is live from the RAM in the return cycle and held afterwards
    assign bus.o_B_RVALID = rvalid_b;
    assign bus.o_C_RVALID = rvalid_c;
    assign bus.o_B_RDATA  = rvalid_b ? bus.i_DATA_FROM_RAM : rdata_b_q;
    assign bus.o_C_RDATA  = rvalid_c ? bus.i_DATA_FROM_RAM : rdata_c_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            last_c    <= 1'b1;
            beat_cnt  <= '0;
            rvalid_b  <= 1'b0;
            rvalid_c  <= 1'b0;
            rdata_b_q <= '0;
            rdata_c_q <= '0;
        end else begin
            // return tracking is per issuer, so a grant switch cannot misroute it
            rvalid_b <= beat_b & ~acc_b.we;
            rvalid_c <= beat_c & ~acc_c.we;
            if (rvalid_b) rdata_b_q <= bus.i_DATA_FROM_RAM;
            if (rvalid_c) rdata_c_q <= bus.i_DATA_FROM_RAM;

            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (bus.i_B_REQ && (!bus.i_C_REQ || last_c)) begin
                        state <= GNT_B;
                    end else if (bus.i_C_REQ) begin
                        state <= GNT_C;
                    end
                end
                GNT_B: begin
                    if (!bus.i_B_REQ) begin
                        beat_cnt <= '0;
                        last_c   <= 1'b0;
                        state    <= bus.i_C_REQ ? GNT_C : IDLE;
                    end else begin
`ifdef ARB_BURST_LIMIT_EN
                        if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                            // limit reached: restart the count, yield only if C waits
                            beat_cnt <= '0;
                            if (bus.i_C_REQ) begin
                                last_c <= 1'b0;
                                state  <= GNT_C;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
`else
                        beat_cnt <= beat_cnt + 1'b1;
`endif
                    end
                end
                GNT_C: begin
                    if (!bus.i_C_REQ) begin
                        beat_cnt <= '0;
                        last_c   <= 1'b1;
                        state    <= bus.i_B_REQ ? GNT_B : IDLE;
                    end else begin
`ifdef ARB_BURST_LIMIT_EN
                        if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                            beat_cnt <= '0;
                            if (bus.i_B_REQ) begin
                                last_c <= 1'b1;
                                state  <= GNT_B;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
`else
                        beat_cnt <= beat_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_ram_arbiter.sv
// Purpose : directed self-checking bench for sample_ram_arbiter with a RAM model and read-return scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_sample_ram_arbiter;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MB = 4;

    logic i_clk = 1'b0;
    logic i_rst;

    sample_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sample_ram_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // synchronous-read RAM model: data valid the cycle after the read strobe
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    always @(posedge i_clk) begin
        if (bus.o_WRITE_ram) mem[bus.o_SAMPLE_INDEX_ram] <= bus.o_SAMPLE_ram;
        if (bus.o_READ_ram)  ram_q <= mem[bus.o_SAMPLE_INDEX_ram];
    end
    assign bus.i_DATA_FROM_RAM = ram_q;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit            is_c;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ret(input bit is_c, input logic [DW-1:0] d);
        exp_t e;
        check("rvalid_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rvalid_port", 32'(is_c), 32'(e.is_c));
            check("rdata", d, e.data);
            check("rvalid_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge i_clk) begin
        if (bus.o_B_RVALID === 1'b1) chk_ret(1'b0, bus.o_B_RDATA);
        if (bus.o_C_RVALID === 1'b1) chk_ret(1'b1, bus.o_C_RDATA);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    task automatic push(input bit is_c, input logic [DW-1:0] d);
        exp_t e;
        e.is_c = is_c;
        e.data = d;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        int b_beats;
        bit own_c;
        for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
        i_rst = 1'b1;
        bus.i_B_REQ = 1'b0; bus.i_B_WE = 1'b0; bus.i_B_ADR = '0; bus.i_B_WDATA = '0;
        bus.i_C_REQ = 1'b0; bus.i_C_WE = 1'b0; bus.i_C_ADR = '0; bus.i_C_WDATA = '0;

        // reset state
        repeat (2) tick();
        smp();
        check("rst_busy",     32'(bus.o_BUSY), 32'd0);
        check("rst_gnt_b",    32'(bus.o_B_GNT), 32'd0);
        check("rst_gnt_c",    32'(bus.o_C_GNT), 32'd0);
        check("rst_rvalid_b", 32'(bus.o_B_RVALID), 32'd0);
        check("rst_rvalid_c", 32'(bus.o_C_RVALID), 32'd0);
        check("rst_rdata_b",  bus.o_B_RDATA, 32'd0);
        check("rst_rdata_c",  bus.o_C_RDATA, 32'd0);
        check("rst_strobes",  32'({bus.o_WRITE_ram, bus.o_READ_ram}), 32'd0);
        tick();
        i_rst = 1'b0;

        // B writes 10 beats, addresses 0..9, data 2..20
        bus.i_B_REQ = 1'b1; bus.i_B_WE = 1'b1; bus.i_B_ADR = '0; bus.i_B_WDATA = 32'd2;
        smp();
        check("b_gnt_latency", 32'(bus.o_B_GNT), 32'd0);
        check("b_no_early_wr", 32'(bus.o_WRITE_ram), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.i_B_ADR = AW'(i); bus.i_B_WDATA = 32'(2 * (i + 1));
            smp();
            check("b_wr_gnt",  32'(bus.o_B_GNT), 32'd1);
            check("b_wr_beat", 32'({bus.o_WRITE_ram, bus.o_READ_ram, bus.o_SAMPLE_INDEX_ram}),
                  32'({1'b1, 1'b0, AW'(i)}));
            check("b_wr_data", bus.o_SAMPLE_ram, 32'(2 * (i + 1)));
        end
        tick();
        bus.i_B_REQ = 1'b0;
        smp();
        check("b_drop_gnt",     32'(bus.o_B_GNT), 32'd1);
        check("b_drop_strobes", 32'({bus.o_WRITE_ram, bus.o_READ_ram}), 32'd0);
        check("b_drop_index",   32'(bus.o_SAMPLE_INDEX_ram), 32'd0);
        tick();
        smp();
        check("idle_busy", 32'(bus.o_BUSY), 32'd0);
        for (int i = 0; i < 10; i++) check("mem_fill", mem[i], 32'(2 * (i + 1)));

        // C reads address 5
        tick();
        bus.i_C_REQ = 1'b1; bus.i_C_WE = 1'b0; bus.i_C_ADR = AW'(5);
        smp();
        check("c_gnt_latency", 32'(bus.o_C_GNT), 32'd0);
        tick();
        smp();
        check("c_gnt", 32'(bus.o_C_GNT), 32'd1);
        check("c_rd_beat", 32'({bus.o_READ_ram, bus.o_WRITE_ram, bus.o_SAMPLE_INDEX_ram}),
              32'({1'b1, 1'b0, AW'(5)}));
        push(1'b1, 32'd12);
        tick();
        bus.i_C_REQ = 1'b0;
        smp();
        check("c_rvalid", 32'(bus.o_C_RVALID), 32'd1);
        tick();
        smp();
        check("c_rvalid_pulse", 32'(bus.o_C_RVALID), 32'd0);
        check("c_rdata_hold",   bus.o_C_RDATA, 32'd12);

        // tie after reset: B first, then C with no idle cycle
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        bus.i_B_REQ = 1'b1; bus.i_B_WE = 1'b1; bus.i_B_ADR = AW'(20); bus.i_B_WDATA = 32'd100;
        bus.i_C_REQ = 1'b1; bus.i_C_WE = 1'b1; bus.i_C_ADR = AW'(21); bus.i_C_WDATA = 32'd200;
        smp();
        check("tie_no_gnt", 32'({bus.o_B_GNT, bus.o_C_GNT}), 32'd0);
        tick();
        smp();
        check("tie_b_first", 32'({bus.o_B_GNT, bus.o_C_GNT}), 32'b10);
        check("tie_b_index", 32'(bus.o_SAMPLE_INDEX_ram), 32'd20);
        tick();
        smp();
        check("tie_b_beat2", 32'({bus.o_B_GNT, bus.o_WRITE_ram}), 32'b11);
        tick();
        bus.i_B_REQ = 1'b0;
        smp();
        check("tie_b_drop", 32'({bus.o_B_GNT, bus.o_WRITE_ram}), 32'b10);
        tick();
        smp();
        check("switch_c_gnt",  32'({bus.o_B_GNT, bus.o_C_GNT, bus.o_BUSY}), 32'b011);
        check("switch_c_beat", 32'({bus.o_WRITE_ram, bus.o_SAMPLE_INDEX_ram}), 32'({1'b1, AW'(21)}));
        check("switch_c_data", bus.o_SAMPLE_ram, 32'd200);
        tick();
        bus.i_C_REQ = 1'b0;
        tick();
        smp();
        check("tie_idle", 32'(bus.o_BUSY), 32'd0);

        // both request continuously: B reads 0..9 cyclically, C writes address 40
        tick();
        bus.i_B_REQ = 1'b1; bus.i_B_WE = 1'b0; bus.i_B_ADR = '0;
        bus.i_C_REQ = 1'b1; bus.i_C_WE = 1'b1; bus.i_C_ADR = AW'(40); bus.i_C_WDATA = 32'd7;
        b_beats = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            bus.i_B_ADR = AW'(b_beats % 10);
            smp();
`ifdef ARB_BURST_LIMIT_EN
            own_c = ((j / MB) % 2) == 1;
            if (j == MB) begin
                check("yield_b_rvalid", 32'(bus.o_B_RVALID), 32'd1);
                check("yield_c_rvalid", 32'(bus.o_C_RVALID), 32'd0);
            end
`else
            own_c = 1'b0;
`endif
            check("cont_gnt", 32'({bus.o_B_GNT, bus.o_C_GNT}), own_c ? 32'b01 : 32'b10);
            if (!own_c) begin
                check("cont_b_rd", 32'({bus.o_READ_ram, bus.o_SAMPLE_INDEX_ram}),
                      32'({1'b1, AW'(b_beats % 10)}));
                push(1'b0, 32'(2 * ((b_beats % 10) + 1)));
                b_beats++;
            end else begin
                check("cont_c_wr", 32'({bus.o_WRITE_ram, bus.o_SAMPLE_INDEX_ram}),
                      32'({1'b1, AW'(40)}));
            end
        end
        tick();
        bus.i_B_REQ = 1'b0;
        tick();
        bus.i_C_REQ = 1'b0;
        tick();
        smp();
        check("cont_idle", 32'(bus.o_BUSY), 32'd0);

        // reset on beat 3 of a B read burst
        tick();
        bus.i_B_REQ = 1'b1; bus.i_B_WE = 1'b0; bus.i_B_ADR = AW'(3);
        tick();
        smp();
        check("rb_beat1", 32'(bus.o_READ_ram), 32'd1);
        push(1'b0, 32'd8);
        tick();
        smp();
        check("rb_beat2", 32'(bus.o_READ_ram), 32'd1);
        push(1'b0, 32'd8);
        tick();
        i_rst = 1'b1;
        smp();
        check("rb_beat3", 32'(bus.o_READ_ram), 32'd1);
        tick();
        smp();
        check("rb_busy",    32'(bus.o_BUSY), 32'd0);
        check("rb_gnt",     32'(bus.o_B_GNT), 32'd0);
        check("rb_strobes", 32'({bus.o_WRITE_ram, bus.o_READ_ram}), 32'd0);
        check("rb_rvalid",  32'(bus.o_B_RVALID), 32'd0);
        check("rb_rdata",   bus.o_B_RDATA, 32'd0);
        tick();
        i_rst = 1'b0;
        bus.i_B_REQ = 1'b0;
        smp();
        check("rb_rvalid_after", 32'(bus.o_B_RVALID), 32'd0);
        tick();
        smp();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
